// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit 7-segment scan controller with a shift-in pattern buffer.
// Optional ghost blanking at the end of each digit period: define DISP_GHOST_BLANK_EN.
module disp_scan_ctrl #(
  parameter int DIGIT_CYCLES = 10000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk_10Mhz,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  output logic [7:0] an_sel,
  output logic [6:0] seg
);

  localparam logic [15:0] CNT_LAST = 16'(DIGIT_CYCLES - 1);

  if (DIGIT_CYCLES < 4 || DIGIT_CYCLES > 65535 ||
      BLANK_CYCLES < 1 || BLANK_CYCLES > DIGIT_CYCLES - 2) begin : g_bad_param
    $error("disp_scan_ctrl: illegal DIGIT_CYCLES/BLANK_CYCLES");
  end

  typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;
`ifdef DISP_GHOST_BLANK_EN
  localparam logic [15:0] BLANK_START = 16'(DIGIT_CYCLES - BLANK_CYCLES);
  typedef enum logic {S_SCAN, S_BLANK} scan_state_t;
`else
  typedef enum logic {S_SCAN} scan_state_t;
`endif

  logic [6:0]  r_buf [8];
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [2:0]  r_clr_idx;
  logic        r_wr_ready;
  logic [7:0]  r_an_sel;
  logic [6:0]  r_seg;
  clr_state_t  r_clr_st;
  scan_state_t r_scan_st;

  logic [15:0] w_cnt_nxt;
  logic        w_cnt_wrap;
  clr_state_t  w_clr_nxt;
  scan_state_t w_scan_nxt;
  logic        w_accept;
  logic        w_clr_wipe;
  logic        w_rdy_nxt;
  logic [7:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_cnt_nxt  = w_cnt_wrap ? 16'd0 : r_cnt + 16'd1;

  // Scan timing free-runs; nothing else in the block can stall it.
  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_wrap) r_idx <= r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (reset) r_scan_st <= S_SCAN;
    else       r_scan_st <= w_scan_nxt;
  end

  always_comb begin
    w_scan_nxt = r_scan_st;
`ifdef DISP_GHOST_BLANK_EN
    case (r_scan_st)
      S_SCAN:  if (w_cnt_nxt >= BLANK_START) w_scan_nxt = S_BLANK;
      S_BLANK: if (w_cnt_nxt == 16'd0) w_scan_nxt = S_SCAN;
      default: w_scan_nxt = S_SCAN;
    endcase
`else
    w_scan_nxt = S_SCAN;
`endif
  end

  always_comb begin
    w_an_nxt  = ~(8'b1 << r_idx);
    w_seg_nxt = ~r_buf[r_idx];
`ifdef DISP_GHOST_BLANK_EN
    if (r_scan_st == S_BLANK) begin
      w_an_nxt  = 8'hFF;
      w_seg_nxt = 7'h7F;
    end
`endif
  end

  // Reset forces the outputs directly since the buffer is only zero after this edge.
  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      r_an_sel <= 8'hFE;
      r_seg    <= 7'h7F;
    end else begin
      r_an_sel <= w_an_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (reset) r_clr_st <= S_IDLE;
    else       r_clr_st <= w_clr_nxt;
  end

  always_comb begin
    w_clr_nxt = r_clr_st;
    case (r_clr_st)
      S_IDLE:  if (clear) w_clr_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_idx == 3'd7) w_clr_nxt = S_IDLE;
      default: w_clr_nxt = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle write; the write is simply dropped.
  always_comb begin
    w_accept   = (r_clr_st == S_IDLE) && wr_en && r_wr_ready && !clear;
    w_clr_wipe = (r_clr_st == S_CLEAR);
    w_rdy_nxt  = (w_clr_nxt == S_IDLE);
  end

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      r_buf      <= '{default: '0};
      r_clr_idx  <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      r_wr_ready <= w_rdy_nxt;
      if (w_clr_wipe) begin
        r_buf[r_clr_idx] <= '0;
        r_clr_idx        <= r_clr_idx + 3'd1;
      end else begin
        r_clr_idx <= '0;
        if (w_accept) begin
          for (int k = 7; k > 0; k--) r_buf[k] <= r_buf[k-1];
          r_buf[0] <= wr_data;
        end
      end
    end
  end

  assign wr_ready = r_wr_ready;
  assign an_sel   = r_an_sel;
  assign seg      = r_seg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard bench for disp_scan_ctrl (DIGIT_CYCLES=4, BLANK_CYCLES=1).
module tb_disp_scan_ctrl;

  localparam int DC = 4;
  localparam int BC = 1;

  logic       clk_10Mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       wr_en     = 1'b0;
  logic [6:0] wr_data   = '0;
  logic       clear     = 1'b0;
  logic       wr_ready;
  logic [7:0] an_sel;
  logic [6:0] seg;

  disp_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk_10Mhz (clk_10Mhz),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clear     (clear),
    .an_sel    (an_sel),
    .seg       (seg)
  );

  always #5 clk_10Mhz = ~clk_10Mhz;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] sg;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: buffer contents, remaining clear cycles, edges since reset release.
  logic [6:0] m_buf [8];
  int         m_clr_left = 0;
  int         m_t = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic cyc(input bit r, input bit we, input logic [6:0] wd, input bit c);
    exp_t e;
    @(negedge clk_10Mhz);
    reset = r; wr_en = we; wr_data = wd; clear = c;
    if (r) begin
      e = '{an: 8'hFE, sg: 7'h7F, rdy: 1'b1};
      m_buf = '{default: '0};
      m_clr_left = 0;
      m_t = 0;
    end else begin
      int digit;
      int phase;
      bit blank;
      digit = (m_t / DC) % 8;
      phase = m_t % DC;
      blank = 1'b0;
`ifdef DISP_GHOST_BLANK_EN
      blank = (phase >= DC - BC);
`endif
      e.an = blank ? 8'hFF : ~(8'h01 << digit);
      e.sg = blank ? 7'h7F : ~m_buf[digit];
      if (m_clr_left > 0) begin
        m_buf[8 - m_clr_left] = '0;
        m_clr_left--;
      end else if (c) begin
        m_clr_left = 8;
      end else if (we) begin
        for (int k = 7; k > 0; k--) m_buf[k] = m_buf[k-1];
        m_buf[0] = wd;
      end
      e.rdy = (m_clr_left == 0);
      m_t++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 7'($urandom), 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    int   lows;
    forever begin
      @(posedge clk_10Mhz);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an_sel", int'(an_sel), int'(e.an));
        check("seg", int'(seg), int'(e.sg));
        check("wr_ready", int'(wr_ready), int'(e.rdy));
        lows = 0;
        for (int b = 0; b < 8; b++) if (!an_sel[b]) lows++;
        check("onehot_low", int'(lows <= 1), 1);
      end
    end
  end

  initial begin : stim
    cyc(1'b1, 1'b0, 7'h00, 1'b0);
    cyc(1'b1, 1'b0, 7'h00, 1'b0);
    idle(40);

    cyc(1'b0, 1'b1, 7'h06, 1'b0);
    cyc(1'b0, 1'b1, 7'h5B, 1'b0);
    idle(40);

    fill8();
    cyc(1'b0, 1'b0, 7'h00, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 7'($urandom), 1'b0);
    idle(40);

    fill8();
    cyc(1'b0, 1'b1, 7'h11, 1'b1);
    idle(3);
    cyc(1'b0, 1'b1, 7'h22, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 7'($urandom), 1'b0);
    idle(40);

    fill8();
    cyc(1'b0, 1'b0, 7'h00, 1'b1);
    idle(4);
    cyc(1'b1, 1'b1, 7'h33, 1'b0);
    idle(40);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 300) == 0, ($urandom % 3) != 0, 7'($urandom),
          ($urandom % 24) == 0);
    end

    @(posedge clk_10Mhz);
    #3;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 10000, clk_10Mhz cycles each digit is selected (1 ms); legal range 4..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, dead-time cycles at the end of each digit period; legal range 1..DIGIT_CYCLES-2.
REQ-003 SHALL have port clk_10Mhz  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  requester offers a segment pattern.
REQ-006 SHALL have port wr_data  input  7  segment pattern, active-high, bit0=a .. bit6=g.
REQ-007 SHALL have port wr_ready  output  1  registered; controller can accept a write.
REQ-008 SHALL have port clear  input  1  single-cycle request to blank the whole buffer.
REQ-009 SHALL have port an_sel  output  8  registered, active-low one-hot digit anode select.
REQ-010 SHALL have port seg  output  7  registered, active-low cathode pattern.

Function
REQ-011 SHALL hold an 8-entry x 7-bit pattern buffer buf[0..7]; buf[k] drives digit k.
REQ-012 SHALL accept a write when wr_en and wr_ready are both 1 on a clock edge and clear is 0.
REQ-013 SHALL on accept shift left: buf[k] <= buf[k-1] for k=7..1, buf[0] <= wr_data; buf[7] old value is lost.
REQ-014 SHALL give clear priority over a same-cycle write: the write is dropped, not stored, not retried.
REQ-015 SHALL run a CLEAR sequence on clear=1 while IDLE: 8 cycles, cycle i writes buf[i] <= 0 for i=0..7, then return to IDLE.
REQ-016 SHALL drive wr_ready=0 from the cycle after clear is sampled through the last CLEAR cycle, 1 otherwise.
REQ-017 SHALL ignore clear asserted while in CLEAR; no restart, no extension.
REQ-018 SHALL keep a period counter 0..DIGIT_CYCLES-1 and a 3-bit digit index; index increments when the counter wraps, 7 wraps to 0.
REQ-019 SHALL in SCAN drive an_sel = ~(8'b1 << index) and seg = ~buf[index], both registered (1-cycle latency from buffer/index change).
REQ-020 SHALL reflect a buffer write on seg of the currently selected digit on the second edge after accept.
REQ-021 SHALL keep scanning during CLEAR and during writes; scan timing never stalls.
REQ-022 SHALL never drive more than one an_sel bit low in any cycle.

Reset
REQ-023 SHALL on reset=1 set buf to all 0, period counter 0, index 0, scan FSM to SCAN, clear FSM to IDLE.
REQ-024 SHALL drive an_sel=8'hFE, seg=7'h7F, wr_ready=1 on the first edge with reset=1 and hold while reset=1.
REQ-025 SHALL abort a CLEAR in progress and any pending write when reset asserts mid-operation.

Configuration
REQ-026 SHALL compile ghost-blanking with macro DISP_GHOST_BLANK_EN.
REQ-027 SHALL with DISP_GHOST_BLANK_EN defined enter BLANK when counter >= DIGIT_CYCLES-BLANK_CYCLES: an_sel=8'hFF, seg=7'h7F; return to SCAN with the counter wrap.
REQ-028 SHALL without DISP_GHOST_BLANK_EN select the digit for all DIGIT_CYCLES cycles; BLANK_CYCLES is unused and the BLANK state is absent.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=1)
REQ-029 SHALL check reset: assert reset 2 cycles -> an_sel=8'hFE, seg=7'h7F, wr_ready=1; release -> an_sel steps FE,FD,FB,..,7F,FE every 4 cycles (no macro).
REQ-030 SHALL check writes: write 7'h06 then 7'h5B -> buf[0]=5B, buf[1]=06; seg=~5B=7'h24 while an_sel=FE, seg=~06=7'h79 while an_sel=FD.
REQ-031 SHALL check clear: fill 8 writes, pulse clear -> wr_ready=0 for 8 cycles, wr_en ignored, then all digits show seg=7'h7F, wr_ready=1.
REQ-032 SHALL check collision: wr_en=1 with clear=1 same cycle -> data not stored, CLEAR runs; clear repulsed mid-CLEAR -> still exactly 8 cycles.
REQ-033 SHALL check macro: with DISP_GHOST_BLANK_EN -> per digit 3 cycles one-hot low then 1 cycle an_sel=8'hFF, seg=7'h7F; never two anodes low.
REQ-034 SHALL check reset mid-CLEAR at cycle 4 -> next edge buf all 0, wr_ready=1, an_sel=8'hFE.
